// File: rtl/ssd_scan_decoder.sv
// Receive-side decoder for the multiplexed 4-digit seven-segment bus: rebuilds 16-bit frames from stable digits.
// Optional SSD_DP_CAPTURE_EN: capture decimal points into dp_out and include dp in stability comparison.
module ssd_scan_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int FRAME_TMO  = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ssd_ctl,
    input  logic [7:0]  D_ssd,
    output logic [15:0] value,
    output logic        frame_done,
    output logic [3:0]  digit_err,
    output logic        ghost_err,
    output logic [3:0]  dp_out
);

    localparam int            TW       = $clog2(FRAME_TMO + 1);
    localparam logic [7:0]    STB      = 8'(STABLE_CYC);
    localparam logic [TW-1:0] TMO_LOAD = TW'(FRAME_TMO);

    logic [7:0] seg_in;
`ifdef SSD_DP_CAPTURE_EN
    assign seg_in = D_ssd;
`else
    logic unused_dp;
    assign unused_dp = D_ssd[0];
    assign seg_in    = {D_ssd[7:1], 1'b1};
`endif

    logic [3:0]    ctl_m, ctl_s, prev_ctl;
    logic [7:0]    seg_m, seg_s, prev_seg;
    logic [7:0]    cnt, cnt_next;
    logic          armed;
    logic [3:0]    mask;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   sh_val;
    logic [3:0]    sh_err;

    logic          ctl_chg, same_smp, armed_eff, stable_hit;
    logic          one_low, multi_low, capture, ghost_hit;
    logic [1:0]    dig_idx;
    logic [4:0]    dec;

    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0000001: decode_seg = {1'b0, 4'h0};
            7'b1001111: decode_seg = {1'b0, 4'h1};
            7'b0010010: decode_seg = {1'b0, 4'h2};
            7'b0000110: decode_seg = {1'b0, 4'h3};
            7'b1001100: decode_seg = {1'b0, 4'h4};
            7'b0100100: decode_seg = {1'b0, 4'h5};
            7'b0100000: decode_seg = {1'b0, 4'h6};
            7'b0001111: decode_seg = {1'b0, 4'h7};
            7'b0000000: decode_seg = {1'b0, 4'h8};
            7'b0000100: decode_seg = {1'b0, 4'h9};
            7'b0001000: decode_seg = {1'b0, 4'hA};
            7'b1100000: decode_seg = {1'b0, 4'hB};
            7'b0110001: decode_seg = {1'b0, 4'hC};
            7'b1000010: decode_seg = {1'b0, 4'hD};
            7'b0110000: decode_seg = {1'b0, 4'hE};
            7'b0111000: decode_seg = {1'b0, 4'hF};
            default:    decode_seg = {1'b1, 4'h0};
        endcase
    endfunction

    always_comb begin
        ctl_chg  = (ctl_s != prev_ctl);
        same_smp = !ctl_chg && (seg_s == prev_seg);
        if (!same_smp)
            cnt_next = 8'd1;
        else if (cnt >= STB)
            cnt_next = STB;
        else
            cnt_next = cnt + 8'd1;
        armed_eff  = armed | ctl_chg;
        stable_hit = armed_eff && (cnt_next == STB);
        one_low    = $onehot(~ctl_s);
        multi_low  = !$onehot0(~ctl_s);
        capture    = stable_hit && one_low;
        ghost_hit  = stable_hit && multi_low;
        case (ctl_s)
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: dig_idx = 2'd0;
        endcase
        dec = decode_seg(seg_s[7:1]);
    end

    // Synchroniser and previous-sample flops reset to the idle bus (all lines high)
    // so the first post-reset samples never look like a ghost select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_m    <= 4'hF;
            ctl_s    <= 4'hF;
            seg_m    <= 8'hFF;
            seg_s    <= 8'hFF;
            prev_ctl <= 4'hF;
            prev_seg <= 8'hFF;
            cnt      <= 8'd0;
            armed    <= 1'b1;
        end else begin
            ctl_m    <= ssd_ctl;
            ctl_s    <= ctl_m;
            seg_m    <= seg_in;
            seg_s    <= seg_m;
            prev_ctl <= ctl_s;
            prev_seg <= seg_s;
            cnt      <= cnt_next;
            armed    <= (capture || ghost_hit) ? 1'b0 : armed_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask       <= 4'h0;
            tmo_cnt    <= '0;
            sh_val     <= 16'h0;
            sh_err     <= 4'h0;
            value      <= 16'h0;
            digit_err  <= 4'h0;
            frame_done <= 1'b0;
            ghost_err  <= 1'b0;
        end else begin
            frame_done <= (mask == 4'hF);
            ghost_err  <= ghost_hit;
            if (mask == 4'hF) begin
                value     <= sh_val;
                digit_err <= sh_err;
            end
            // A capture landing on the publish cycle starts the next frame.
            if (capture) begin
                mask    <= ((mask == 4'hF) ? 4'h0 : mask) | ~ctl_s;
                tmo_cnt <= TMO_LOAD;
                sh_val[{dig_idx, 2'b00} +: 4] <= dec[3:0];
                sh_err[dig_idx]               <= dec[4];
            end else if (mask == 4'hF) begin
                mask <= 4'h0;
            end else if (mask != 4'h0) begin
                if (tmo_cnt <= TW'(1))
                    mask <= 4'h0;
                else
                    tmo_cnt <= tmo_cnt - TW'(1);
            end
        end
    end

`ifdef SSD_DP_CAPTURE_EN
    logic [3:0] sh_dp;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_dp  <= 4'h0;
            dp_out <= 4'h0;
        end else begin
            if (capture)
                sh_dp[dig_idx] <= ~seg_s[0];
            if (mask == 4'hF)
                dp_out <= sh_dp;
        end
    end
`else
    assign dp_out = 4'h0;
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench for ssd_scan_decoder: table-driven frames with a scoreboard, plus reset/ghost/timeout sequences.
module tb_ssd_scan_decoder;

    localparam int STB = 4;
    localparam int TMO = 200;
`ifdef SSD_DP_CAPTURE_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ssd_ctl;
    logic [7:0]  D_ssd;
    logic [15:0] value;
    logic        frame_done;
    logic [3:0]  digit_err;
    logic        ghost_err;
    logic [3:0]  dp_out;

    always #5 clk = ~clk;

    ssd_scan_decoder #(.STABLE_CYC(STB), .FRAME_TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ssd_ctl    (ssd_ctl),
        .D_ssd      (D_ssd),
        .value      (value),
        .frame_done (frame_done),
        .digit_err  (digit_err),
        .ghost_err  (ghost_err),
        .dp_out     (dp_out)
    );

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  err;
        logic [3:0]  dp;
    } exp_t;

    typedef struct packed {
        logic [3:0][7:0] d;
        logic [15:0]     val;
        logic [3:0]      err;
        logic [3:0]      dp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_pass = 0, n_total = 0, done_cnt = 0, ghost_cnt = 0;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;  4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
        endcase
    endfunction

    function automatic logic [3:0] sel(input int i);
        logic [3:0] s;
        s = 4'b0001 << i;
        return ~s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [7:0] seg, input int cyc);
        @(negedge clk);
        ssd_ctl = ctl;
        D_ssd   = seg;
        repeat (cyc) @(posedge clk);
    endtask

    task automatic scan_digit(input int i, input logic [3:0] n);
        drive(sel(i), {seg7(n), 1'b1}, 8);
    endtask

    task automatic blank(input int cyc);
        drive(4'hF, 8'hFF, cyc);
    endtask

    task automatic push_exp(input logic [15:0] v, input logic [3:0] e, input logic [3:0] dp);
        exp_t x;
        x.val = v;
        x.err = e;
        x.dp  = DP_EN ? dp : 4'h0;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            exp_t x;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                x = sb.pop_front();
                check("sb_value", 32'(value), 32'(x.val));
                check("sb_digit_err", 32'(digit_err), 32'(x.err));
                check("sb_dp_out", 32'(dp_out), 32'(x.dp));
            end
        end
        if (rst_n === 1'b1 && ghost_err === 1'b1) ghost_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, g0;

        vecs[0].d = {{seg7(4'h4), 1'b1}, {seg7(4'h3), 1'b1}, {seg7(4'h2), 1'b1}, {seg7(4'h1), 1'b1}};
        vecs[0].val = 16'h4321; vecs[0].err = 4'b0000; vecs[0].dp = 4'b0000;
        vecs[1].d = {{seg7(4'hD), 1'b1}, 8'hFF, {seg7(4'hB), 1'b1}, {seg7(4'hA), 1'b1}};
        vecs[1].val = 16'hD0BA; vecs[1].err = 4'b0100; vecs[1].dp = 4'b0000;
        vecs[2].d = {{seg7(4'h5), 1'b1}, {seg7(4'h6), 1'b1}, {seg7(4'h7), 1'b0}, {seg7(4'h8), 1'b1}};
        vecs[2].val = 16'h5678; vecs[2].err = 4'b0000; vecs[2].dp = 4'b0010;
        vecs[3].d = {{seg7(4'h0), 1'b1}, {seg7(4'hF), 1'b1}, {7'b0101010, 1'b1}, {seg7(4'h9), 1'b1}};
        vecs[3].val = 16'h0F09; vecs[3].err = 4'b0010; vecs[3].dp = 4'b0000;
        vecs[4].d = {{seg7(4'h8), 1'b0}, {seg7(4'h8), 1'b0}, {seg7(4'h8), 1'b0}, {seg7(4'h8), 1'b0}};
        vecs[4].val = 16'h8888; vecs[4].err = 4'b0000; vecs[4].dp = 4'b1111;
        vecs[5].d = {{seg7(4'h7), 1'b1}, {seg7(4'hB), 1'b1}, {seg7(4'hC), 1'b1}, {seg7(4'hE), 1'b1}};
        vecs[5].val = 16'h7BCE; vecs[5].err = 4'b0000; vecs[5].dp = 4'b0000;

        rst_n   = 1'b0;
        ssd_ctl = 4'hF;
        D_ssd   = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_digit_err", 32'(digit_err), 32'h0);
        check("rst_ghost_err", 32'(ghost_err), 32'h0);
        check("rst_dp_out", 32'(dp_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        blank(4);

        for (int v = 0; v < 6; v++) begin
            d0 = done_cnt;
            push_exp(vecs[v].val, vecs[v].err, vecs[v].dp);
            for (int i = 0; i < 4; i++) drive(sel(i), vecs[v].d[i], 8);
            blank(6);
            check($sformatf("vec%0d_frames", v), 32'(done_cnt - d0), 32'd1);
            check($sformatf("vec%0d_sb_empty", v), 32'(sb.size()), 32'd0);
        end

        // Latency: capture on the 4th synchronised sample, frame_done one cycle later.
        push_exp(16'hFA50, 4'h0, 4'h0);
        scan_digit(0, 4'h0);
        scan_digit(1, 4'h5);
        scan_digit(2, 4'hA);
        @(negedge clk);
        ssd_ctl = sel(3);
        D_ssd   = {seg7(4'hF), 1'b1};
        repeat (2 + STB) @(posedge clk);
        #1 check("latency_early", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 check("latency_hit", 32'(frame_done), 32'd1);
        repeat (3) @(posedge clk);
        blank(6);
        check("latency_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-frame discards the partial frame.
        scan_digit(0, 4'h2);
        scan_digit(1, 4'h3);
        @(negedge clk);
        ssd_ctl = sel(2);
        D_ssd   = {seg7(4'h9), 1'b1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_digit_err", 32'(digit_err), 32'h0);
        check("midrst_dp_out", 32'(dp_out), 32'h0);
        ssd_ctl = 4'hF;
        D_ssd   = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        scan_digit(2, 4'h9);
        scan_digit(3, 4'h1);
        blank(TMO + 10);
        check("midrst_no_frame", 32'(done_cnt - d0), 32'd0);
        check("midrst_value_hold", 32'(value), 32'h0);
        push_exp(16'h1413, 4'h0, 4'h0);
        scan_digit(0, 4'h3); scan_digit(1, 4'h1); scan_digit(2, 4'h4); scan_digit(3, 4'h1);
        blank(6);
        check("midrst_full_frame", 32'(done_cnt - d0), 32'd1);

        // Ghost select: one pulse per dwell, no capture; blank raises nothing.
        g0 = ghost_cnt; d0 = done_cnt;
        drive(4'b1100, {seg7(4'h6), 1'b1}, 10);
        check("ghost_once", 32'(ghost_cnt - g0), 32'd1);
        g0 = ghost_cnt;
        blank(10);
        check("blank_no_ghost", 32'(ghost_cnt - g0), 32'd0);
        scan_digit(1, 4'h6); scan_digit(2, 4'h6); scan_digit(3, 4'h6);
        blank(TMO + 10);
        check("ghost_no_capture", 32'(done_cnt - d0), 32'd0);
        check("ghost_no_error", 32'(ghost_cnt - g0), 32'd0);

        // Timeout discards digits 0,1; shadows may linger but outputs hold.
        d0 = done_cnt;
        scan_digit(0, 4'h2); scan_digit(1, 4'h7);
        blank(TMO + 1);
        scan_digit(2, 4'h5); scan_digit(3, 4'h5);
        blank(TMO + 10);
        check("tmo_no_frame", 32'(done_cnt - d0), 32'd0);
        check("tmo_value_hold", 32'(value), 32'h1413);
        push_exp(16'h6D2B, 4'h0, 4'h0);
        scan_digit(0, 4'hB); scan_digit(1, 4'h2); scan_digit(2, 4'hD); scan_digit(3, 4'h6);
        blank(6);
        check("tmo_then_frame", 32'(done_cnt - d0), 32'd1);

        // Idle just under the timeout keeps the partial frame.
        d0 = done_cnt;
        push_exp(16'hE93C, 4'h0, 4'h0);
        scan_digit(0, 4'hC); scan_digit(1, 4'h3);
        blank(TMO - 20);
        scan_digit(2, 4'h9); scan_digit(3, 4'hE);
        blank(6);
        check("near_tmo_frame", 32'(done_cnt - d0), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
